// File: rtl/csr_trap_controller_pkg.sv
// Shared constants for the user-mode trap sequencer: CSR indices, cause codes,
// ustatus/uie bit positions and the sequencer state type.
package csr_trap_controller_pkg;

  localparam logic [6:0] CSR_USTATUS  = 7'd0;
  localparam logic [6:0] CSR_UIE      = 7'd4;
  localparam logic [6:0] CSR_UTVEC    = 7'd5;
  localparam logic [6:0] CSR_USCRATCH = 7'd64;
  localparam logic [6:0] CSR_UEPC     = 7'd65;
  localparam logic [6:0] CSR_UCAUSE   = 7'd66;
  localparam logic [6:0] CSR_UTVAL    = 7'd67;
  localparam logic [6:0] CSR_UIP      = 7'd68;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL          = 4'd8;

  localparam logic [3:0] IRQ_CODE_SW    = 4'd0;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd4;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd8;

  localparam int USTATUS_UIE  = 0;
  localparam int USTATUS_UPIE = 4;

  localparam int UIE_USIE = 0;
  localparam int UIE_UTIE = 4;
  localparam int UIE_UEIE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_STATUS = 3'd2,
    ST_REDIR  = 3'd3,
    ST_RET_ST = 3'd4,
    ST_RET_PC = 3'd5
  } trap_state_e;

  // Vectored-mode offset: each interrupt cause owns one 4-byte slot.
  function automatic logic [31:0] vector_offset(input logic [3:0] code);
    return {26'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/csr_trap_controller_irq_enc.sv
// Masks pending interrupt lines with uie/global enable and priority-encodes the
// winner: external > timer > software.
module csr_trap_controller_irq_enc
  import csr_trap_controller_pkg::*;
(
  input  logic [2:0] irq_i,
  input  logic [2:0] irq_en_i,
  input  logic       global_en_i,
  output logic       any_o,
  output logic [3:0] code_o
);

  logic [2:0] pend;

  always_comb begin
    pend   = irq_i & irq_en_i & {3{global_en_i}};
    any_o  = |pend;
    code_o = IRQ_CODE_SW;
    if (pend[2]) begin
      code_o = IRQ_CODE_EXT;
    end else if (pend[1]) begin
      code_o = IRQ_CODE_TIMER;
    end
  end

endmodule

// File: rtl/csr_trap_controller.sv
// User-mode trap sequencer: stalls the CPU, writes ucause/uepc/utval/ustatus
// over fixed multi-cycle sequences and redirects the PC for traps and URET.
module csr_trap_controller
  import csr_trap_controller_pkg::*;
#(
  parameter int          CAUSE_W         = 4,
  parameter logic [31:0] RESET_PC_TARGET = 32'h0000_0000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iCPUCSRWrite,
  input  logic [6:0]         iCPUCSRAddr,
  input  logic [31:0]        iCPUCSRData,
  input  logic               iExcValid,
  input  logic [CAUSE_W-1:0] iExcCause,
  input  logic [31:0]        iExcPC,
  input  logic [31:0]        iExcTval,
  input  logic               iUret,
  input  logic               iInstrDone,
  input  logic [2:0]         iIRQ,
  input  logic [31:0]        iUSTATUS,
  input  logic [31:0]        iUIE,
  input  logic [31:0]        iUTVEC,
  input  logic [31:0]        iUEPC,
  output logic               oCSRWrite,
  output logic [6:0]         oCSRAddr,
  output logic [31:0]        oCSRData,
  output logic               oUCAUSEWrite,
  output logic [31:0]        oUCAUSEData,
  output logic               oUEPCWrite,
  output logic [31:0]        oUEPCData,
  output logic               oStall,
  output logic               oPCLoad,
  output logic [31:0]        oPCTarget
);

  trap_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic        is_irq_q, is_irq_d;
  logic [3:0]  irq_code_q, irq_code_d;

  logic        irq_any;
  logic [3:0]  irq_code;
  logic [31:0] tvec_base;
  logic [31:0] status_trap;
  logic [31:0] status_ret;
  logic        unused_uie;

  csr_trap_controller_irq_enc u_irq_enc (
    .irq_i      (iIRQ),
    .irq_en_i   ({iUIE[UIE_UEIE], iUIE[UIE_UTIE], iUIE[UIE_USIE]}),
    .global_en_i(iUSTATUS[USTATUS_UIE]),
    .any_o      (irq_any),
    .code_o     (irq_code)
  );

  assign unused_uie = ^{iUIE[31:9], iUIE[7:5], iUIE[3:1]};

  assign tvec_base = {iUTVEC[31:2], 2'b00};

  always_comb begin
    status_trap               = iUSTATUS;
    status_trap[USTATUS_UPIE] = iUSTATUS[USTATUS_UIE];
    status_trap[USTATUS_UIE]  = 1'b0;
    status_ret                = iUSTATUS;
    status_ret[USTATUS_UIE]   = iUSTATUS[USTATUS_UPIE];
    status_ret[USTATUS_UPIE]  = 1'b1;
  end

  // Event acceptance only happens in IDLE; every other state is a fixed walk.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    tval_d     = tval_q;
    is_irq_d   = is_irq_q;
    irq_code_d = irq_code_q;
    case (state_q)
      ST_IDLE: begin
        if (iExcValid) begin
          cause_d    = {{(32-CAUSE_W){1'b0}}, iExcCause};
          epc_d      = iExcPC;
          tval_d     = iExcTval;
          is_irq_d   = 1'b0;
          irq_code_d = 4'd0;
          state_d    = ST_SAVE;
        end else if (iUret) begin
          state_d = ST_RET_ST;
        end else if (iInstrDone && irq_any) begin
          cause_d    = {1'b1, 27'b0, irq_code};
          epc_d      = iExcPC;
          tval_d     = 32'd0;
          is_irq_d   = 1'b1;
          irq_code_d = irq_code;
          state_d    = ST_SAVE;
        end
      end
      ST_SAVE:   state_d = ST_STATUS;
      ST_STATUS: state_d = ST_REDIR;
      ST_REDIR:  state_d = ST_IDLE;
      ST_RET_ST: state_d = ST_RET_PC;
      ST_RET_PC: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      tval_q     <= 32'd0;
      is_irq_q   <= 1'b0;
      irq_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      tval_q     <= tval_d;
      is_irq_q   <= is_irq_d;
      irq_code_q <= irq_code_d;
    end
  end

  // Outputs decode from the registered state; the IDLE pass-through is the
  // only path that depends on CPU inputs and is forced low while in reset.
  always_comb begin
    oCSRWrite    = 1'b0;
    oCSRAddr     = 7'd0;
    oCSRData     = 32'd0;
    oUCAUSEWrite = 1'b0;
    oUCAUSEData  = 32'd0;
    oUEPCWrite   = 1'b0;
    oUEPCData    = 32'd0;
    oStall       = 1'b0;
    oPCLoad      = 1'b0;
    oPCTarget    = RESET_PC_TARGET;
    case (state_q)
      ST_IDLE: begin
        if (iRST_N) begin
          oCSRWrite = iCPUCSRWrite & ~iExcValid;
          oCSRAddr  = iCPUCSRAddr;
          oCSRData  = iCPUCSRData;
        end
      end
      ST_SAVE: begin
        oStall       = 1'b1;
        oUCAUSEWrite = 1'b1;
        oUCAUSEData  = cause_q;
        oUEPCWrite   = 1'b1;
        oUEPCData    = epc_q;
        oCSRWrite    = 1'b1;
        oCSRAddr     = CSR_UTVAL;
        oCSRData     = tval_q;
      end
      ST_STATUS: begin
        oStall    = 1'b1;
        oCSRWrite = 1'b1;
        oCSRAddr  = CSR_USTATUS;
        oCSRData  = status_trap;
      end
      ST_REDIR: begin
        oStall  = 1'b1;
        oPCLoad = 1'b1;
        if (iUTVEC[1:0] == 2'b01 && is_irq_q) begin
          oPCTarget = tvec_base + vector_offset(irq_code_q);
        end else begin
          oPCTarget = tvec_base;
        end
      end
      ST_RET_ST: begin
        oStall    = 1'b1;
        oCSRWrite = 1'b1;
        oCSRAddr  = CSR_USTATUS;
        oCSRData  = status_ret;
      end
      ST_RET_PC: begin
        oStall    = 1'b1;
        oPCLoad   = 1'b1;
        oPCTarget = iUEPC;
      end
      default: begin
        oStall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_controller.sv
// Bench for csr_trap_controller: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_csr_trap_controller;

  localparam logic [31:0] RST_TGT = 32'h0000_0000;

  logic        iCLK;
  logic        iRST_N;
  logic        iCPUCSRWrite;
  logic [6:0]  iCPUCSRAddr;
  logic [31:0] iCPUCSRData;
  logic        iExcValid;
  logic [3:0]  iExcCause;
  logic [31:0] iExcPC;
  logic [31:0] iExcTval;
  logic        iUret;
  logic        iInstrDone;
  logic [2:0]  iIRQ;
  logic [31:0] iUSTATUS;
  logic [31:0] iUIE;
  logic [31:0] iUTVEC;
  logic [31:0] iUEPC;
  logic        oCSRWrite;
  logic [6:0]  oCSRAddr;
  logic [31:0] oCSRData;
  logic        oUCAUSEWrite;
  logic [31:0] oUCAUSEData;
  logic        oUEPCWrite;
  logic [31:0] oUEPCData;
  logic        oStall;
  logic        oPCLoad;
  logic [31:0] oPCTarget;

  int n_cmp = 0;
  int n_err = 0;

  logic [139:0] exp_q[$];

  csr_trap_controller #(
    .CAUSE_W        (4),
    .RESET_PC_TARGET(RST_TGT)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iCPUCSRWrite(iCPUCSRWrite),
    .iCPUCSRAddr (iCPUCSRAddr),
    .iCPUCSRData (iCPUCSRData),
    .iExcValid   (iExcValid),
    .iExcCause   (iExcCause),
    .iExcPC      (iExcPC),
    .iExcTval    (iExcTval),
    .iUret       (iUret),
    .iInstrDone  (iInstrDone),
    .iIRQ        (iIRQ),
    .iUSTATUS    (iUSTATUS),
    .iUIE        (iUIE),
    .iUTVEC      (iUTVEC),
    .iUEPC       (iUEPC),
    .oCSRWrite   (oCSRWrite),
    .oCSRAddr    (oCSRAddr),
    .oCSRData    (oCSRData),
    .oUCAUSEWrite(oUCAUSEWrite),
    .oUCAUSEData (oUCAUSEData),
    .oUEPCWrite  (oUEPCWrite),
    .oUEPCData   (oUEPCData),
    .oStall      (oStall),
    .oPCLoad     (oPCLoad),
    .oPCTarget   (oPCTarget)
  );

  // Clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Output snapshot; data fields only matter when their write enable is set.
  function automatic logic [139:0] pack(input logic we, input logic [6:0] a, input logic [31:0] d,
                                        input logic cwe, input logic [31:0] cd,
                                        input logic ewe, input logic [31:0] ed,
                                        input logic st, input logic ld, input logic [31:0] tg);
    return {we, we ? a : 7'd0, we ? d : 32'd0, cwe, cwe ? cd : 32'd0,
            ewe, ewe ? ed : 32'd0, st, ld, tg};
  endfunction

  function automatic logic [139:0] obs_vec();
    return pack(oCSRWrite, oCSRAddr, oCSRData, oUCAUSEWrite, oUCAUSEData,
                oUEPCWrite, oUEPCData, oStall, oPCLoad, oPCTarget);
  endfunction

  // Reference model: a trap expands into three stalled cycles of effects.
  task automatic push_trap(input logic [31:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval, input logic is_int, input logic [3:0] code);
    logic [31:0] st_val;
    logic [31:0] tgt;
    st_val = (iUSTATUS & ~32'h11) | (iUSTATUS[0] ? 32'h10 : 32'h0);
    tgt    = (iUTVEC & ~32'h3);
    if (iUTVEC[1:0] == 2'd1 && is_int) tgt = tgt + 32'(code) * 4;
    exp_q.push_back(pack(1'b1, 7'd67, tval, 1'b1, cause, 1'b1, epc, 1'b1, 1'b0, RST_TGT));
    exp_q.push_back(pack(1'b1, 7'd0, st_val, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, RST_TGT));
    exp_q.push_back(pack(1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, tgt));
  endtask

  task automatic push_ret();
    logic [31:0] rv;
    rv = (iUSTATUS & ~32'h11) | 32'h10 | {31'd0, iUSTATUS[4]};
    exp_q.push_back(pack(1'b1, 7'd0, rv, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, RST_TGT));
    exp_q.push_back(pack(1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, iUEPC));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle_check(input string tag);
    logic [139:0] e;
    logic [2:0]   intp;
    logic [3:0]   code;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = pack(iCPUCSRWrite & ~iExcValid, iCPUCSRAddr, iCPUCSRData, 1'b0, 32'd0,
               1'b0, 32'd0, 1'b0, 1'b0, RST_TGT);
      intp = iIRQ & {iUIE[8], iUIE[4], iUIE[0]} & {3{iUSTATUS[0]}};
      code = intp[2] ? 4'd8 : (intp[1] ? 4'd4 : 4'd0);
      if (iExcValid) push_trap({28'd0, iExcCause}, iExcPC, iExcTval, 1'b0, 4'd0);
      else if (iUret) push_ret();
      else if (iInstrDone && intp != 3'd0) push_trap(32'h8000_0000 | 32'(code), iExcPC, 32'd0, 1'b1, code);
    end
    check_eq(tag, obs_vec(), e);
  endtask

  task automatic tick(input string tag);
    cycle_check(tag);
    @(negedge iCLK);
  endtask

  // Driver tasks
  task automatic clear_events();
    iCPUCSRWrite = 1'b0;
    iCPUCSRAddr  = 7'd0;
    iCPUCSRData  = 32'd0;
    iExcValid    = 1'b0;
    iExcCause    = 4'd0;
    iExcPC       = 32'd0;
    iExcTval     = 32'd0;
    iUret        = 1'b0;
    iInstrDone   = 1'b0;
    iIRQ         = 3'd0;
  endtask

  task automatic rand_inputs();
    logic [3:0] causes [5];
    causes       = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8};
    iCPUCSRWrite = 1'($urandom_range(0, 1));
    iCPUCSRAddr  = 7'($urandom_range(0, 127));
    iCPUCSRData  = $urandom();
    iExcValid    = ($urandom_range(0, 7) == 0);
    iExcCause    = causes[$urandom_range(0, 4)];
    iExcPC       = $urandom();
    iExcTval     = $urandom();
    iUret        = ($urandom_range(0, 7) == 0);
    iInstrDone   = 1'($urandom_range(0, 1));
    iIRQ         = 3'($urandom_range(0, 7));
    if (exp_q.size() == 0) begin
      iUSTATUS = $urandom();
      if ($urandom_range(0, 3) != 0) iUSTATUS[0] = 1'b1;
      iUIE   = $urandom();
      iUTVEC = $urandom();
      iUEPC  = $urandom();
    end
  endtask

  initial begin
    iRST_N   = 1'b0;
    clear_events();
    iUSTATUS = 32'd0;
    iUIE     = 32'd0;
    iUTVEC   = 32'd0;
    iUEPC    = 32'd0;
    iCPUCSRWrite = 1'b1;
    iCPUCSRAddr  = 7'd64;
    iCPUCSRData  = 32'hAA;
    #3;
    check_eq("reset_outputs", obs_vec(), 140'd0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    clear_events();

    // Illegal instruction, direct mode
    iExcValid = 1'b1; iExcCause = 4'd2; iExcPC = 32'h0040_0010; iExcTval = 32'h0000_FFFF;
    iUTVEC = 32'h0040_1000; iUSTATUS = 32'h1; iUIE = 32'h0;
    tick("ill_accept");
    clear_events();
    cycle_check("ill_save");
    check_eq("ill_ucause", 140'(oUCAUSEData), 140'(32'h2));
    check_eq("ill_uepc", 140'(oUEPCData), 140'(32'h0040_0010));
    check_eq("ill_utval", 140'({oCSRAddr, oCSRData}), 140'({7'd67, 32'h0000_FFFF}));
    @(negedge iCLK);
    cycle_check("ill_status");
    check_eq("ill_ustatus", 140'(oCSRData), 140'(32'h10));
    @(negedge iCLK);
    cycle_check("ill_redir");
    check_eq("ill_target", 140'({oPCLoad, oPCTarget}), 140'({1'b1, 32'h0040_1000}));
    @(negedge iCLK);

    // External + timer pending, vectored mode
    iIRQ = 3'b110; iUIE = 32'h110; iUSTATUS = 32'h1; iUTVEC = 32'h0040_1001;
    iInstrDone = 1'b1; iExcPC = 32'h0040_0020;
    tick("irq_accept");
    clear_events();
    cycle_check("irq_save");
    check_eq("irq_ucause", 140'(oUCAUSEData), 140'(32'h8000_0008));
    @(negedge iCLK);
    tick("irq_status");
    cycle_check("irq_redir");
    check_eq("irq_target", 140'(oPCTarget), 140'(32'h0040_1020));
    @(negedge iCLK);

    // Exception drops a concurrent CPU write; interrupt lets it through
    iExcValid = 1'b1; iExcCause = 4'd8; iCPUCSRWrite = 1'b1; iCPUCSRAddr = 7'd64; iCPUCSRData = 32'hAA;
    cycle_check("exc_cpu_accept");
    check_eq("exc_drops_cpu_wr", 140'(oCSRWrite), 140'(1'b0));
    @(negedge iCLK);
    clear_events();
    repeat (3) tick("exc_cpu_seq");
    iIRQ = 3'b001; iUIE = 32'h1; iUSTATUS = 32'h1; iInstrDone = 1'b1;
    iCPUCSRWrite = 1'b1; iCPUCSRAddr = 7'd64; iCPUCSRData = 32'hAA;
    cycle_check("irq_cpu_accept");
    check_eq("irq_keeps_cpu_wr", 140'({oCSRWrite, oCSRAddr, oCSRData}), 140'({1'b1, 7'd64, 32'hAA}));
    @(negedge iCLK);
    clear_events();
    repeat (3) tick("irq_cpu_seq");

    // URET
    iUret = 1'b1; iUSTATUS = 32'h10; iUEPC = 32'h0040_0014;
    tick("uret_accept");
    clear_events();
    cycle_check("uret_status");
    check_eq("uret_ustatus", 140'(oCSRData), 140'(32'h11));
    @(negedge iCLK);
    cycle_check("uret_pc");
    check_eq("uret_target", 140'({oPCLoad, oPCTarget}), 140'({1'b1, 32'h0040_0014}));
    @(negedge iCLK);

    // Globally disabled interrupts never trap
    iIRQ = 3'b111; iUIE = 32'h111; iUSTATUS = 32'h0; iInstrDone = 1'b1;
    tick("gie_off_0");
    cycle_check("gie_off_1");
    check_eq("gie_off_stall", 140'(oStall), 140'(1'b0));
    @(negedge iCLK);
    clear_events();

    // Reset asserted in the middle of STATUS
    iExcValid = 1'b1; iExcCause = 4'd4; iUSTATUS = 32'h1; iUTVEC = 32'h0000_2000;
    tick("rst_mid_accept");
    clear_events();
    tick("rst_mid_save");
    cycle_check("rst_mid_status");
    iCPUCSRWrite = 1'b1; iCPUCSRAddr = 7'd64; iCPUCSRData = 32'h55;
    iRST_N = 1'b0;
    #1;
    check_eq("rst_mid_outputs", obs_vec(), 140'd0);
    exp_q.delete();
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_events();
    repeat (3) tick("post_rst_idle");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_trap_controller.md
Name: csr_trap_controller

Overview:
Sequencer for the user-mode CSR file (N-extension trap handling).
- Detects synchronous exceptions, enabled pending interrupts and URET.
- Stalls the CPU and drives the CSR file write ports (ucause, uepc, generic port) over fixed multi-cycle sequences, then redirects the PC.
- Arbitrates the CSR file's single generic write port between CPU csrrw-class writes and the trap sequence.

Parameters:
- CAUSE_W, 4, width of synchronous exception cause code.
- RESET_PC_TARGET, 32'h0000_0000, value driven on oPCTarget when no load is active.

Ports:
- iCLK  in  1  clock; all state updates on posedge.
- iRST_N  in  1  asynchronous active-low reset.
- iCPUCSRWrite  in  1  CPU requests a generic CSR write.
- iCPUCSRAddr  in  7  CPU CSR index.
- iCPUCSRData  in  32  CPU CSR write data.
- iExcValid  in  1  synchronous exception raised by the current instruction.
- iExcCause  in  CAUSE_W  exception code: 0 instr-misaligned, 2 illegal, 4 load-misaligned, 6 store-misaligned, 8 ecall.
- iExcPC  in  32  faulting PC, or next-instruction PC at an interrupt boundary.
- iExcTval  in  32  trap value (bad address or instruction word).
- iUret  in  1  URET retiring.
- iInstrDone  in  1  instruction boundary; interrupts are sampled only here.
- iIRQ  in  3  pending lines: [2] external, [1] timer, [0] software.
- iUSTATUS, iUIE, iUTVEC, iUEPC  in  32 each  combinational read taps from the CSR file.
- oCSRWrite  out  1  generic port write enable.
- oCSRAddr  out  7  generic port index.
- oCSRData  out  32  generic port data.
- oUCAUSEWrite  out  1  ucause write enable.
- oUCAUSEData  out  32  ucause write data.
- oUEPCWrite  out  1  uepc write enable.
- oUEPCData  out  32  uepc write data.
- oStall  out  1  CPU must hold the PC and suppress commit.
- oPCLoad  out  1  one-cycle PC redirect strobe.
- oPCTarget  out  32  redirect address.

Behaviour:
- CSR indices: ustatus 0, uie 4, utvec 5, uscratch 64, uepc 65, ucause 66, utval 67, uip 68.
- Reset (async, iRST_N=0): state IDLE, latches cleared, all outputs 0, oPCTarget=RESET_PC_TARGET. Reset mid-sequence aborts immediately; partial CSR writes are not undone.
- Interrupt pending: intp[k] = iIRQ[k] & iUIE[bit k] & iUSTATUS[0], using uie bits 8, 4, 0. Priority: external > timer > software. Codes 8, 4, 0.
- IDLE:
  - oStall=0.
  - CPU write passes through: oCSRWrite=iCPUCSRWrite, addr/data forwarded combinationally.
  - Event priority: iExcValid > iUret > (iInstrDone & |intp).
  - On exception: CPU write that cycle is dropped. Latch cause={0,code}, epc=iExcPC, tval=iExcTval. Go to SAVE.
  - On interrupt: CPU write passes through. Latch cause={1,27'b0,code}, epc=iExcPC, tval=0. Go to SAVE.
  - On URET: CPU write passes through. Go to RET_ST.
- SAVE: oStall=1. oUCAUSEWrite=1 with latched cause; oUEPCWrite=1 with latched epc; generic port writes utval(67)=tval. Next: STATUS.
- STATUS: oStall=1. Generic write ustatus = iUSTATUS with bit4 (UPIE) set to iUSTATUS[0] and bit0 (UIE) cleared. Next: REDIR.
- REDIR: oStall=1, oPCLoad=1.
  - Base = {iUTVEC[31:2],2'b00}.
  - If iUTVEC[1:0]==1 and interrupt: target = base + 4*code.
  - Otherwise (any other mode): target = base.
  - Next: IDLE.
- RET_ST: oStall=1. Generic write ustatus with bit0 = iUSTATUS[4] and bit4 = 1. Next: RET_PC.
- RET_PC: oStall=1, oPCLoad=1, target=iUEPC. Next: IDLE.
- Latency: event accepted at edge T. Trap redirect occurs in cycle T+3; URET redirect in cycle T+2.
- In every non-IDLE state, all inputs other than the CSR taps are ignored; the CPU write is blocked because the CPU is stalled.
- No nesting: UIE is cleared before the redirect.
- Address arithmetic is modulo 2^32.
- When oPCLoad=0: oPCTarget holds RESET_PC_TARGET; all write enables are 0 except where stated.

Decomposition:
- Shared defines in Parametros.v: CSR indices, exception and interrupt cause codes, ustatus bit positions (UIE=0, UPIE=4), and state encoding (3-bit: IDLE, SAVE, STATUS, REDIR, RET_ST, RET_PC).
- One sub-module: trap_irq_encoder. Combinational masking plus priority encode of iIRQ/iUIE/iUSTATUS into {any, code}.

Test Plan:
- Illegal instruction at PC=0x0040_0010, tval=0x0000_FFFF, utvec=0x0040_1000, ustatus=1.
  -> SAVE: ucause=2, uepc=0x0040_0010, utval=0xFFFF.
  -> STATUS: ustatus=0x10.
  -> T+3: oPCLoad, target 0x0040_1000.
- External + timer pending, uie=0x110, ustatus=1, utvec=0x0040_1001, iInstrDone.
  -> ucause=0x8000_0008.
  -> target 0x0040_1020.
- iExcValid and iCPUCSRWrite(addr 64, data 0xAA) in the same cycle -> no write to 64; trap proceeds. Repeat with an interrupt instead -> write to 64 occurs.
- URET with ustatus=0x10, uepc=0x0040_0014.
  -> ustatus written 0x11.
  -> T+2: oPCLoad, target 0x0040_0014.
- iIRQ=3'b111 with ustatus[0]=0 -> no trap; oStall stays 0.
- iRST_N low during STATUS -> all outputs 0 asynchronously; after release, IDLE and no oPCLoad.
